uart_rx_word_assembler: RTL
===========================

Name: uart_rx_word_assembler

Overview:
- Sits between the UART byte receiver and uart_detect_done. One instance is used per operand (A and B).
- Collects BYTES consecutive received bytes into one floating-point operand word.
- Presents the word with a level-valid flag. This flag drives the i_en_a / i_en_b inputs of the done detector.
- Guards against stale partial words with an inter-byte timeout. Guards against corrupt frames by discarding the partial word.

Parameters:
- DATA_W, 8, bits per UART byte.
- BYTES, 4, bytes per operand word (4 gives a 32-bit float).
- LSB_FIRST, 1, 1 places the first byte in word[DATA_W-1:0]; 0 places it in the top byte.
- TIMEOUT_CYC, 100000, maximum i_clk cycles allowed between bytes of one word. Must be >= 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_rx_valid  in  1  one-cycle strobe, new byte on i_rx_data.
- i_rx_data  in  DATA_W  received byte.
- i_rx_frame_err  in  1  qualifies i_rx_valid; 1 means the byte had a stop-bit error.
- i_clear  in  1  consumer has taken the word; release the hold.
- o_word  out  BYTES*DATA_W  last completed operand word.
- o_word_valid  out  1  level, high from word completion until i_clear.
- o_byte_cnt  out  $clog2(BYTES+1)  bytes collected in the current word.
- o_timeout_err  out  1  one-cycle pulse; partial word dropped on timeout.
- o_frame_err  out  1  one-cycle pulse; partial word dropped on a framing error.
- o_overrun  out  1  one-cycle pulse; byte arrived in HOLD and was dropped.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst, sampled at the rising edge of i_clk.
- Reset values:
  - state=IDLE.
  - o_word=0, o_word_valid=0, o_byte_cnt=0.
  - All error pulses 0.
  - Internal shift register and timeout counter are 0.
- Reset mid-collection or in HOLD discards everything. Reset has priority over all inputs.
- States: IDLE, COLLECT, HOLD.
- A "good byte" is i_rx_valid=1 with i_rx_frame_err=0. A "bad byte" is i_rx_valid=1 with i_rx_frame_err=1.
- IDLE:
  - Good byte: write it into the slot for byte 0, set cnt=1, clear the timer.
  - If BYTES=1, go to HOLD. Otherwise go to COLLECT.
  - Bad byte: pulse o_frame_err, stay in IDLE.
- COLLECT:
  - Good byte: write slot cnt, cnt+1, clear the timer.
  - When cnt reaches BYTES, copy the assembled word to o_word and set o_word_valid=1 on the same edge. Go to HOLD with cnt=0.
  - Latency: o_word_valid is high the cycle after the last byte's strobe.
  - Bad byte: pulse o_frame_err, set cnt=0, go to IDLE.
  - No byte: timer increments. When timer == TIMEOUT_CYC-1, pulse o_timeout_err, set cnt=0, go to IDLE.
  - A good byte on the same cycle as the timeout threshold wins; no timeout occurs.
- HOLD:
  - o_word and o_word_valid are held stable.
  - i_clear=1 drops o_word_valid next cycle. o_word keeps its value.
  - Any byte without i_clear: dropped, pulse o_overrun, stay in HOLD.
  - i_clear together with a good byte: the clear takes effect and the byte becomes byte 0 of a new word (next state COLLECT, cnt=1). No overrun.
  - i_clear together with a bad byte: clear takes effect, pulse o_frame_err, go to IDLE.
- i_clear in IDLE or COLLECT has no effect.
- o_word changes only on word completion. Partial words are never visible on o_word.
- Slot placement:
  - LSB_FIRST=1: slot k is bits [k*DATA_W +: DATA_W].
  - LSB_FIRST=0: slot k is bits [(BYTES-1-k)*DATA_W +: DATA_W].
- Timer width is $clog2(TIMEOUT_CYC). It never wraps, because it clears on the threshold.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef {IDLE, COLLECT, HOLD};
  - default constants UART_DATA_W=8, UART_OP_BYTES=4;
  - the default timeout constant.
- One natural sub-module: uart_interbyte_timer. It is a counter with clear/enable inputs and a threshold-hit output, parameterised by TIMEOUT_CYC, and is reusable by the TX side.
- Slot insertion and state logic stay in the top module.

Test Plan:
- Reset, then good bytes 0x00,0x00,0x80,0x3F spaced 10 cycles apart (LSB_FIRST=1). Expect o_word=0x3F800000 and o_word_valid=1 one cycle after the 4th strobe; o_byte_cnt steps 1,2,3 then 0.
- LSB_FIRST=0, bytes 0x40,0x49,0x0F,0xDB. Expect o_word=0x40490FDB. Then pulse i_clear: o_word_valid=0 next cycle and o_word is still 0x40490FDB.
- TIMEOUT_CYC=16: send 2 bytes, then idle 16 cycles. Expect a single o_timeout_err pulse, o_byte_cnt=0, and o_word unchanged. Four new bytes then form a correct word.
- Byte 3 arrives with i_rx_frame_err=1. Expect o_frame_err pulse, state IDLE, o_word_valid stays 0.
- In HOLD: a byte without i_clear gives an o_overrun pulse and o_word is unchanged. Then i_clear together with byte 0x11 gives o_word_valid=0, o_byte_cnt=1, no overrun; bytes 0x22,0x33,0x44 follow and give o_word=0x44332211.
- Assert i_rst for 1 cycle after 3 bytes. Expect all outputs at reset values next cycle. A following 4-byte word assembles with no leftover bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-side FSM states and default operand framing constants.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_OP_BYTES    = 4;
    localparam int UART_TIMEOUT_CYC = 100000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } uart_rx_state_e;

endpackage

// File: rtl/uart_interbyte_timer.sv
// Inter-byte gap counter: counts enabled cycles and flags when the gap reaches TIMEOUT_CYC-1.
module uart_interbyte_timer
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = UART_TIMEOUT_CYC
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q;

    // A clear on the threshold cycle suppresses the hit, so a late byte still wins.
    assign o_hit = i_en && !i_clr && (cnt_q == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || o_hit) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Assembles BYTES consecutive UART bytes into one operand word, holding it until the consumer clears it.
module uart_rx_word_assembler
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int BYTES       = UART_OP_BYTES,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int TIMEOUT_CYC = UART_TIMEOUT_CYC
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rx_valid,
    input  logic [DATA_W-1:0]          i_rx_data,
    input  logic                       i_rx_frame_err,
    input  logic                       i_clear,
    output logic [BYTES*DATA_W-1:0]    o_word,
    output logic                       o_word_valid,
    output logic [$clog2(BYTES+1)-1:0] o_byte_cnt,
    output logic                       o_timeout_err,
    output logic                       o_frame_err,
    output logic                       o_overrun
);

    localparam int WORD_W = BYTES * DATA_W;
    localparam int CNT_W  = $clog2(BYTES + 1);
    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    function automatic int slot_lsb(input int k);
        return LSB_FIRST ? (k * DATA_W) : ((BYTES - 1 - k) * DATA_W);
    endfunction

    uart_rx_state_e      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, slot;
    logic [WORD_W-1:0]   asm_q, asm_ins, word_q;
    logic [IDX_W-1:0]    ins_lsb;
    logic                valid_q, valid_d;
    logic                frame_d, timeout_d, overrun_d;
    logic                frame_q, timeout_q, overrun_q;
    logic                accept, last, load_word, clear_hold;
    logic                good, bad, tmr_hit, tmr_clr, tmr_en;

    assign good = i_rx_valid && !i_rx_frame_err;
    assign bad  = i_rx_valid &&  i_rx_frame_err;

    assign tmr_en  = (state_q == COLLECT);
    assign tmr_clr = (state_q != COLLECT) || i_rx_valid;

    uart_interbyte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (tmr_clr),
        .i_en  (tmr_en),
        .o_hit (tmr_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (good) state_d = (BYTES == 1) ? HOLD : COLLECT;
            end
            COLLECT: begin
                if (good) begin
                    state_d = (int'(cnt_q) + 1 == BYTES) ? HOLD : COLLECT;
                end else if (bad || tmr_hit) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // A clear releases the hold; a byte on the same cycle restarts collection.
                if (i_clear) begin
                    if (good) state_d = (BYTES == 1) ? HOLD : COLLECT;
                    else      state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept     = 1'b0;
        slot       = '0;
        frame_d    = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;
        clear_hold = 1'b0;
        case (state_q)
            IDLE: begin
                accept  = good;
                frame_d = bad;
            end
            COLLECT: begin
                accept    = good;
                slot      = cnt_q;
                frame_d   = bad;
                timeout_d = !i_rx_valid && tmr_hit;
            end
            HOLD: begin
                if (i_clear) begin
                    clear_hold = 1'b1;
                    accept     = good;
                    frame_d    = bad;
                end else begin
                    overrun_d  = i_rx_valid;
                end
            end
            default: ;
        endcase

        last      = (int'(slot) + 1 == BYTES);
        load_word = accept && last;

        if (accept) begin
            cnt_d = last ? '0 : slot + CNT_W'(1);
        end else if (state_q == COLLECT && !frame_d && !timeout_d) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = '0;
        end

        // Byte 0 starts from a clean word so no stale slots leak into it.
        ins_lsb = IDX_W'(slot_lsb(int'(slot)));
        asm_ins = (slot == '0) ? '0 : asm_q;
        asm_ins[ins_lsb +: DATA_W] = i_rx_data;

        if (load_word)       valid_d = 1'b1;
        else if (clear_hold) valid_d = 1'b0;
        else                 valid_d = valid_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            if (accept)    asm_q  <= asm_ins;
            if (load_word) word_q <= asm_ins;
        end
    end

    assign o_word        = word_q;
    assign o_word_valid  = valid_q;
    assign o_byte_cnt    = cnt_q;
    assign o_timeout_err = timeout_q;
    assign o_frame_err   = frame_q;
    assign o_overrun     = overrun_q;

endmodule
